ibex_rf_wb_arbiter: RTL and testbench
=====================================

// Module: ibex_rf_wb_arbiter
// PURPOSE
//  Write-back arbiter and load scoreboard directly upstream of the register file write port.
//  Merges EX results and LSU load responses onto the single RF write port.
//  Tracks destination registers of outstanding loads and raises stall_o to ID on RAW/WAW hazards.
//  RF read ports stay combinational; this block has no forwarding paths.
// PARAMETERS
//  RV32E      0   1: 16 architectural registers; address bit 4 is ignored for matching
//  DataWidth  32  RF data width
//  LoadDepth  2   max outstanding loads (rd FIFO depth, >=1, power of 2)
// PORTS
//  clk_i            in   1      clock
//  rst_ni           in   1      reset, asynchronous, active-low
//  ex_we_i          in   1      EX result write request
//  ex_waddr_i       in   5      EX destination register
//  ex_wdata_i       in   DW     EX result
//  ex_ready_o       out  1      EX write accepted this cycle when ex_we_i & ex_ready_o
//  lsu_req_i        in   1      load issued (push rd)
//  lsu_rd_i         in   5      load destination register
//  lsu_req_ready_o  out  1      rd FIFO can accept a push
//  lsu_rvalid_i     in   1      load response (in order)
//  lsu_rdata_i      in   DW     load data
//  lsu_err_i        in   1      load faulted: pop FIFO, no RF write
//  id_ren_a_i/_b_i  in   1      ID reads port a/b
//  id_raddr_a_i/_b_i in  5      ID read addresses
//  id_we_i          in   1      ID instruction writes rd
//  id_waddr_i       in   5      ID destination register
//  stall_o          out  1      hazard: hold ID
//  rf_we_o          out  1      RF write enable
//  rf_waddr_o       out  5      RF write address
//  rf_wdata_o       out  DW     RF write data
// BEHAVIOUR
//  Reset: FIFO empty, skid empty; rf_we_o=0, ex_ready_o=1, lsu_req_ready_o=1, stall_o=0.
//  rd FIFO: push on lsu_req_i & lsu_req_ready_o; lsu_req_ready_o = !full.
//   - No push-through-pop when full.
//   - Pop on lsu_rvalid_i.
//   - lsu_rvalid_i while empty: ignored, assertion fires.
//   - Pointers wrap modulo LoadDepth; count is 0..LoadDepth.
//  RF port selection (combinational, same cycle), priority order:
//   1. LSU response (rd = FIFO head; write only if !lsu_err_i and rd != 0).
//   2. Skid entry.
//   3. EX direct.
//  Skid buffer (1 entry); ex_ready_o = !skid_valid.
//   - Accepted EX write that loses to an LSU response: captured in skid, drained the next cycle with no response.
//   - Skid holds while responses keep arriving.
//  x0: writes to address 0 never assert rf_we_o; x0 is never pending; pushes with rd=0 still occupy the FIFO.
//  Hazard: pend(r) = r != 0 and (r matches a valid FIFO entry, or skid_valid & skid addr == r).
//   - stall_o = (id_ren_a_i & pend(a)) | (id_ren_b_i & pend(b)) | (id_we_i & pend(waddr)).
//   - Combinational, sampled on current state; a same-cycle pop does not clear the stall.
//  Simultaneous push & pop (not full): count unchanged; head advances.
//  Async reset mid-operation discards FIFO and skid contents; no RF write follows.
// STRUCTURE
//  Shared package: rf_addr_t (5-bit) and wb_src_e {WB_LSU, WB_SKID, WB_EX}.
//  One sub-module: ibex_rd_fifo (LoadDepth x 5-bit, valid vector exported for the hazard compare).
//  Top level holds the skid register, priority mux and hazard logic.
// TESTING
//  1. ex_we=1 wa=5 wd=0xA5 alone -> same cycle rf_we=1, waddr=5, wdata=0xA5; ex_ready=1.
//  2. Load rd=7 issued; ID reads x7 -> stall_o=1 until rvalid with data 0x1234 writes x7; stall clears next cycle.
//  3. Same cycle ex (x3, 0x11) and rvalid (x9, 0x22) -> x9 written; next cycle x3=0x11 from skid; ex_ready low for exactly 1 cycle.
//  4. Two loads pushed (LoadDepth=2) -> lsu_req_ready=0; third push held; after one rvalid, ready=1.
//  5. Load rd=4 with lsu_err=1 -> no RF write; FIFO pops; stall on x4 clears.
//  6. Load rd=0 and ex wa=0 -> rf_we_o never asserts; stall_o stays 0; reset mid-load leaves FIFO empty.

Source files
------------

// File: rtl/ibex_rf_wb_arbiter_pkg.sv
// ibex_rf_wb_arbiter_pkg: shared register-address type, write-back source select and address compare key
package ibex_rf_wb_arbiter_pkg;

    typedef logic [4:0] rf_addr_t;

    typedef enum logic [1:0] {WB_LSU, WB_SKID, WB_EX} wb_src_e;

    function automatic rf_addr_t addr_key(rf_addr_t a, logic rv32e);
        return rv32e ? {1'b0, a[3:0]} : a;
    endfunction

endpackage

// File: rtl/ibex_rf_wb_arbiter_if.sv
// ibex_rf_wb_arbiter_if: EX, LSU, ID and RF write-port signals around the write-back arbiter
interface ibex_rf_wb_arbiter_if #(
    parameter int unsigned DataWidth = 32
);
    import ibex_rf_wb_arbiter_pkg::*;

    logic                 ex_we;
    rf_addr_t             ex_waddr;
    logic [DataWidth-1:0] ex_wdata;
    logic                 ex_ready;
    logic                 lsu_req;
    rf_addr_t             lsu_rd;
    logic                 lsu_req_ready;
    logic                 lsu_rvalid;
    logic [DataWidth-1:0] lsu_rdata;
    logic                 lsu_err;
    logic                 id_ren_a;
    logic                 id_ren_b;
    rf_addr_t             id_raddr_a;
    rf_addr_t             id_raddr_b;
    logic                 id_we;
    rf_addr_t             id_waddr;
    logic                 stall;
    logic                 rf_we;
    rf_addr_t             rf_waddr;
    logic [DataWidth-1:0] rf_wdata;

    modport master (
        output ex_we, ex_waddr, ex_wdata, lsu_req, lsu_rd, lsu_rvalid, lsu_rdata, lsu_err,
               id_ren_a, id_ren_b, id_raddr_a, id_raddr_b, id_we, id_waddr,
        input  ex_ready, lsu_req_ready, stall, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  ex_we, ex_waddr, ex_wdata, lsu_req, lsu_rd, lsu_rvalid, lsu_rdata, lsu_err,
               id_ren_a, id_ren_b, id_raddr_a, id_raddr_b, id_we, id_waddr,
        output ex_ready, lsu_req_ready, stall, rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/ibex_rd_fifo.sv
// ibex_rd_fifo: in-order FIFO of outstanding load destinations, exposing every slot for hazard checks
module ibex_rd_fifo
    import ibex_rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  rf_addr_t             rd_i,
    input  logic                 pop_i,
    output logic                 full_o,
    output logic                 empty_o,
    output rf_addr_t             head_o,
    output logic     [Depth-1:0] valid_o,
    output rf_addr_t [Depth-1:0] entries_o
);
    localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;

    logic     [PtrW-1:0]  wptr, rptr;
    logic     [Depth-1:0] valid;
    rf_addr_t [Depth-1:0] mem;
    logic                 push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return p == PtrW'(Depth - 1) ? '0 : p + 1'b1;
    endfunction

    assign full_o    = &valid;
    assign empty_o   = ~|valid;
    assign push      = push_i & ~full_o;
    assign pop       = pop_i & ~empty_o;
    assign head_o    = mem[rptr];
    assign valid_o   = valid;
    assign entries_o = mem;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            valid <= '0;
        end else begin
            wptr  <= push ? ptr_inc(wptr) : wptr;
            rptr  <= pop ? ptr_inc(rptr) : rptr;
            valid <= (valid | (push ? Depth'(1) << wptr : '0)) & ~(pop ? Depth'(1) << rptr : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= rd_i;
    end

    pop_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) pop_i |-> !empty_o);

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// ibex_rf_wb_arbiter: merges EX results and load responses onto the RF write port and stalls ID on load hazards
module ibex_rf_wb_arbiter
    import ibex_rf_wb_arbiter_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LoadDepth = 2
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    ibex_rf_wb_arbiter_if.slave bus
);
    logic                     fifo_full, fifo_empty;
    rf_addr_t                 fifo_head;
    logic     [LoadDepth-1:0] fifo_valid;
    rf_addr_t [LoadDepth-1:0] fifo_entries;
    logic                     rsp, ex_acc, skid_valid;
    rf_addr_t                 skid_addr, waddr;
    logic     [DataWidth-1:0] skid_data;
    wb_src_e                  src;

    ibex_rd_fifo #(.Depth(LoadDepth)) u_rd_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (bus.lsu_req),
        .rd_i      (bus.lsu_rd),
        .pop_i     (bus.lsu_rvalid),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head),
        .valid_o   (fifo_valid),
        .entries_o (fifo_entries)
    );

    function automatic logic nz(rf_addr_t a);
        return addr_key(a, RV32E) != '0;
    endfunction

    function automatic logic is_pend(rf_addr_t r, logic [LoadDepth-1:0] v, rf_addr_t [LoadDepth-1:0] e,
                                     logic sv, rf_addr_t sa);
        logic hit;
        hit = sv & (addr_key(sa, RV32E) == addr_key(r, RV32E));
        for (int i = 0; i < LoadDepth; i++) hit |= v[i] & (addr_key(e[i], RV32E) == addr_key(r, RV32E));
        return nz(r) & hit;
    endfunction

    // A response occupies the port even when it faults or targets x0
    assign rsp               = bus.lsu_rvalid & ~fifo_empty;
    assign ex_acc            = bus.ex_we & ~skid_valid;
    assign bus.ex_ready      = ~skid_valid;
    assign bus.lsu_req_ready = ~fifo_full;

    always_comb begin
        src          = rsp ? WB_LSU : skid_valid ? WB_SKID : WB_EX;
        waddr        = src == WB_LSU ? fifo_head : src == WB_SKID ? skid_addr : bus.ex_waddr;
        bus.rf_waddr = waddr;
        bus.rf_wdata = src == WB_LSU ? bus.lsu_rdata : src == WB_SKID ? skid_data : bus.ex_wdata;
        bus.rf_we    = (src == WB_LSU ? ~bus.lsu_err : src == WB_SKID ? 1'b1 : bus.ex_we) & nz(waddr);
    end

    always_comb begin
        bus.stall = (bus.id_ren_a & is_pend(bus.id_raddr_a, fifo_valid, fifo_entries, skid_valid, skid_addr))
                  | (bus.id_ren_b & is_pend(bus.id_raddr_b, fifo_valid, fifo_entries, skid_valid, skid_addr))
                  | (bus.id_we    & is_pend(bus.id_waddr,   fifo_valid, fifo_entries, skid_valid, skid_addr));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
        end else begin
            skid_valid <= skid_valid ? rsp : ex_acc & rsp;
            skid_addr  <= ex_acc & rsp ? bus.ex_waddr : skid_addr;
            skid_data  <= ex_acc & rsp ? bus.ex_wdata : skid_data;
        end
    end

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// tb_ibex_rf_wb_arbiter: directed vector table plus reset corner sequences for the write-back arbiter
module tb_ibex_rf_wb_arbiter;
    import ibex_rf_wb_arbiter_pkg::*;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    typedef struct packed {
        logic        ex_we;
        logic [4:0]  ex_wa;
        logic [31:0] ex_wd;
        logic        req;
        logic [4:0]  rd;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        ra_en;
        logic [4:0]  ra;
        logic        rb_en;
        logic [4:0]  rb;
        logic        iw_en;
        logic [4:0]  iw;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_exr;
        logic        e_rqr;
        logic        e_stall;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vq[$];

    ibex_rf_wb_arbiter_if #(.DataWidth(32)) bus ();

    ibex_rf_wb_arbiter #(.RV32E(1'b0), .DataWidth(32), .LoadDepth(2)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(logic ex_we, logic [4:0] ex_wa, logic [31:0] ex_wd,
                                logic req, logic [4:0] rd, logic rv, logic [31:0] rdata, logic err,
                                logic ra_en, logic [4:0] ra, logic rb_en, logic [4:0] rb,
                                logic iw_en, logic [4:0] iw,
                                logic e_we, logic [4:0] e_wa, logic [31:0] e_wd,
                                logic e_exr, logic e_rqr, logic e_stall);
        return {ex_we, ex_wa, ex_wd, req, rd, rv, rdata, err, ra_en, ra, rb_en, rb, iw_en, iw,
                e_we, e_wa, e_wd, e_exr, e_rqr, e_stall};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.ex_we      = v.ex_we;
        bus.ex_waddr   = v.ex_wa;
        bus.ex_wdata   = v.ex_wd;
        bus.lsu_req    = v.req;
        bus.lsu_rd     = v.rd;
        bus.lsu_rvalid = v.rv;
        bus.lsu_rdata  = v.rdata;
        bus.lsu_err    = v.err;
        bus.id_ren_a   = v.ra_en;
        bus.id_raddr_a = v.ra;
        bus.id_ren_b   = v.rb_en;
        bus.id_raddr_b = v.rb;
        bus.id_we      = v.iw_en;
        bus.id_waddr   = v.iw;
    endtask

    task automatic check_out(string tag, vec_t v);
        chk({tag, " rf_we"}, 32'(bus.rf_we), 32'(v.e_we));
        if (v.e_we) begin
            chk({tag, " rf_waddr"}, 32'(bus.rf_waddr), 32'(v.e_wa));
            chk({tag, " rf_wdata"}, bus.rf_wdata, v.e_wd);
        end
        chk({tag, " ex_ready"}, 32'(bus.ex_ready), 32'(v.e_exr));
        chk({tag, " lsu_req_ready"}, 32'(bus.lsu_req_ready), 32'(v.e_rqr));
        chk({tag, " stall"}, 32'(bus.stall), 32'(v.e_stall));
    endtask

    initial begin
        vec_t z;
        //        ex_we wa     wd           req rd     rv rdata        err ra_en ra    rb_en rb    iw_en iw   | we wa    wd          exr rqr stall
        vq.push_back(mk(T, 5'd5,  32'hA5,   F, 5'd0,  F, 32'h0,    F, F, 5'd0,  F, 5'd0, F, 5'd0,  T, 5'd5,  32'hA5,   T, T, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    T, 5'd7,  F, 32'h0,    F, T, 5'd7,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    F, 5'd0,  F, 32'h0,    F, T, 5'd7,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, T));
        vq.push_back(mk(F, 5'd0,  32'h0,    F, 5'd0,  F, 32'h0,    F, F, 5'd0,  T, 5'd7, F, 5'd0,  F, 5'd0,  32'h0,    T, T, T));
        vq.push_back(mk(F, 5'd0,  32'h0,    F, 5'd0,  T, 32'h1234, F, T, 5'd7,  F, 5'd0, F, 5'd0,  T, 5'd7,  32'h1234, T, T, T));
        vq.push_back(mk(F, 5'd0,  32'h0,    F, 5'd0,  F, 32'h0,    F, T, 5'd7,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    T, 5'd9,  F, 32'h0,    F, F, 5'd0,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, F));
        vq.push_back(mk(T, 5'd3,  32'h11,   F, 5'd0,  T, 32'h22,   F, F, 5'd0,  F, 5'd0, F, 5'd0,  T, 5'd9,  32'h22,   T, T, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    F, 5'd0,  F, 32'h0,    F, T, 5'd3,  F, 5'd0, F, 5'd0,  T, 5'd3,  32'h11,   F, T, T));
        vq.push_back(mk(F, 5'd0,  32'h0,    F, 5'd0,  F, 32'h0,    F, T, 5'd3,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    T, 5'd10, F, 32'h0,    F, F, 5'd0,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    T, 5'd11, F, 32'h0,    F, F, 5'd0,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    T, 5'd12, F, 32'h0,    F, F, 5'd0,  F, 5'd0, T, 5'd11, F, 5'd0,  32'h0,    T, F, T));
        vq.push_back(mk(F, 5'd0,  32'h0,    T, 5'd12, T, 32'hAA,   F, F, 5'd0,  F, 5'd0, F, 5'd0,  T, 5'd10, 32'hAA,   T, F, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    T, 5'd12, F, 32'h0,    F, T, 5'd10, F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    F, 5'd0,  T, 32'hBB,   F, F, 5'd0,  F, 5'd0, F, 5'd0,  T, 5'd11, 32'hBB,   T, F, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    F, 5'd0,  T, 32'hCC,   F, T, 5'd12, F, 5'd0, F, 5'd0,  T, 5'd12, 32'hCC,   T, T, T));
        vq.push_back(mk(F, 5'd0,  32'h0,    T, 5'd4,  F, 32'h0,    F, F, 5'd0,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    F, 5'd0,  F, 32'h0,    F, T, 5'd4,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, T));
        vq.push_back(mk(F, 5'd0,  32'h0,    F, 5'd0,  T, 32'hDEAD, T, T, 5'd4,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, T));
        vq.push_back(mk(F, 5'd0,  32'h0,    F, 5'd0,  F, 32'h0,    F, T, 5'd4,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    T, 5'd13, F, 32'h0,    F, F, 5'd0,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, F));
        vq.push_back(mk(T, 5'd6,  32'h66,   T, 5'd14, T, 32'h1,    F, F, 5'd0,  F, 5'd0, F, 5'd0,  T, 5'd13, 32'h1,    T, T, F));
        vq.push_back(mk(T, 5'd8,  32'h88,   F, 5'd0,  T, 32'h2,    F, F, 5'd0,  T, 5'd6, F, 5'd0,  T, 5'd14, 32'h2,    F, T, T));
        vq.push_back(mk(T, 5'd8,  32'h88,   F, 5'd0,  F, 32'h0,    F, F, 5'd0,  F, 5'd0, F, 5'd0,  T, 5'd6,  32'h66,   F, T, F));
        vq.push_back(mk(T, 5'd8,  32'h88,   F, 5'd0,  F, 32'h0,    F, F, 5'd0,  F, 5'd0, F, 5'd0,  T, 5'd8,  32'h88,   T, T, F));
        vq.push_back(mk(T, 5'd0,  32'h55,   T, 5'd0,  F, 32'h0,    F, F, 5'd0,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    F, 5'd0,  F, 32'h0,    F, T, 5'd0,  F, 5'd0, T, 5'd0,  F, 5'd0,  32'h0,    T, T, F));
        vq.push_back(mk(F, 5'd0,  32'h0,    F, 5'd0,  T, 32'h77,   F, F, 5'd0,  F, 5'd0, F, 5'd0,  F, 5'd0,  32'h0,    T, T, F));

        z = '0;
        z.e_exr = T;
        z.e_rqr = T;
        drive(z);
        #1;
        check_out("reset", z);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk_i);
            drive(vq[i]);
            #1;
            check_out($sformatf("row%0d", i), vq[i]);
        end

        // Build up a pending load on x7 and a skid entry for x3, then reset asynchronously mid-cycle
        @(negedge clk_i);
        drive(z);
        bus.lsu_req = T;
        bus.lsu_rd  = 5'd9;
        @(negedge clk_i);
        bus.lsu_rd     = 5'd7;
        bus.lsu_rvalid = T;
        bus.lsu_rdata  = 32'h22;
        bus.ex_we      = T;
        bus.ex_waddr   = 5'd3;
        bus.ex_wdata   = 32'h11;
        @(negedge clk_i);
        drive(z);
        bus.id_ren_a   = T;
        bus.id_raddr_a = 5'd7;
        bus.id_ren_b   = T;
        bus.id_raddr_b = 5'd3;
        #1;
        chk("pre-reset stall", 32'(bus.stall), 32'd1);
        chk("pre-reset ex_ready", 32'(bus.ex_ready), 32'd0);
        chk("pre-reset rf_we", 32'(bus.rf_we), 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("in-reset stall", 32'(bus.stall), 32'd0);
        chk("in-reset ex_ready", 32'(bus.ex_ready), 32'd1);
        chk("in-reset lsu_req_ready", 32'(bus.lsu_req_ready), 32'd1);
        chk("in-reset rf_we", 32'(bus.rf_we), 32'd0);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        chk("post-reset stall", 32'(bus.stall), 32'd0);
        chk("post-reset rf_we", 32'(bus.rf_we), 32'd0);
        chk("post-reset ex_ready", 32'(bus.ex_ready), 32'd1);
        @(negedge clk_i);
        bus.lsu_req = T;
        bus.lsu_rd  = 5'd2;
        @(negedge clk_i);
        bus.lsu_req = T;
        bus.lsu_rd  = 5'd1;
        #1;
        chk("post-reset one entry ready", 32'(bus.lsu_req_ready), 32'd1);
        @(negedge clk_i);
        drive(z);
        #1;
        chk("post-reset two entries ready", 32'(bus.lsu_req_ready), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
